// File: rtl/lzc_normalizer_if.sv
// Valid/ready handshake bundle between a producer, the normalizer and its consumer.
// The DUT connects through the slave modport; the upstream/downstream side uses master.
interface lzc_normalizer_if #(
    parameter int in_width  = 32,
    parameter int exp_width = 8
);
    localparam int shift_width = $clog2((2 ** $clog2(in_width)) + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [in_width-1:0]    in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [in_width-1:0]    out_data;
    logic [shift_width-1:0] out_shift;
    logic [exp_width-1:0]   out_exp;
    logic                   out_zero;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_shift, out_exp, out_zero
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_shift, out_exp, out_zero
    );
endinterface

// File: rtl/lzc_normalizer.sv
// Integer-to-float front end: counts leading zeros, left-justifies the word and
// produces a biased exponent through a two-stage valid/ready pipeline.

module leading_zeros_counter #(
    parameter int width     = 32,
    parameter int cnt_width = 6
) (
    input  logic [width-1:0]     data,
    output logic [cnt_width-1:0] cnt
);
    // The highest set bit is visited last, so it decides the count.
    always_comb begin
        cnt = cnt_width'(width);
        for (int i = 0; i < width; i++) begin
            if (data[i]) cnt = cnt_width'(width - 1 - i);
        end
    end
endmodule

module lzc_normalizer #(
    parameter int in_width  = 32,
    parameter int exp_width = 8,
    parameter int exp_bias  = 127
) (
    input  logic               clk,
    input  logic               rst_n,
    lzc_normalizer_if.slave    bus
);
    localparam int sw = $clog2((2 ** $clog2(in_width)) + 1);
    localparam logic [exp_width-1:0] exp_top = exp_width'(exp_bias + in_width - 1);

    logic                 s1_valid;
    logic [in_width-1:0]  s1_data;
    logic [sw-1:0]        s1_cnt;
    logic                 s1_zero;
    logic [sw-1:0]        lzc_cnt;
    logic                 s1_adv;
    logic                 s2_adv;
    logic [in_width-1:0]  shifted;
    logic [exp_width-1:0] exp_next;

    logic                 out_valid;
    logic [in_width-1:0]  out_data;
    logic [sw-1:0]        out_shift;
    logic [exp_width-1:0] out_exp;
    logic                 out_zero;

    leading_zeros_counter #(
        .width     (in_width),
        .cnt_width (sw)
    ) u_lzc (
        .data (bus.in_data),
        .cnt  (lzc_cnt)
    );

    assign s2_adv       = ~out_valid | bus.out_ready;
    assign s1_adv       = ~s1_valid | s2_adv;
    assign bus.in_ready = s1_adv;
    assign s1_zero      = (s1_cnt == sw'(in_width));

    // Log-depth barrel shifter; the top stage shifts by >= in_width and clears the word.
    always_comb begin
        shifted = s1_data;
        for (int k = 0; k < sw; k++) begin
            if (s1_cnt[k]) shifted = shifted << (1 << k);
        end
    end

    assign exp_next = s1_zero ? '0 : exp_top - exp_width'(s1_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_cnt    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shift <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_data <= bus.in_data;
                    s1_cnt  <= lzc_cnt;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data  <= shifted;
                    out_shift <= s1_cnt;
                    out_exp   <= exp_next;
                    out_zero  <= s1_zero;
                end
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_shift = out_shift;
    assign bus.out_exp   = out_exp;
    assign bus.out_zero  = out_zero;
endmodule

// File: tb/tb_lzc_normalizer.sv
// Directed and randomized-handshake checks of lzc_normalizer at 32 and 24 bits.
module tb_lzc_normalizer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lzc_normalizer_if #(.in_width(32), .exp_width(8)) bus ();
    lzc_normalizer_if #(.in_width(24), .exp_width(8)) bus24 ();

    lzc_normalizer #(.in_width(32), .exp_width(8), .exp_bias(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    lzc_normalizer #(.in_width(24), .exp_width(8), .exp_bias(127)) dut24 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus24)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] src[$];
    logic [46:0] rx[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [46:0] outs();
        return {bus.out_data, bus.out_shift, bus.out_exp, bus.out_zero};
    endfunction

    // Reference: scan from the MSB for the first one.
    function automatic logic [46:0] model(input logic [31:0] d);
        int lz = 32;
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) begin
                lz = 31 - i;
                break;
            end
        end
        if (lz == 32) return {32'h0, 6'd32, 8'd0, 1'b1};
        return {d << lz, 6'(lz), 8'(158 - lz), 1'b0};
    endfunction

    task automatic single(input string tag, input logic [31:0] d, input logic [46:0] exp);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        check({tag, "_lat"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check(tag, 64'(outs()), 64'(exp));
    endtask

    // mode 0: consumer stalled for the first 7 cycles; mode 1: random valid/ready.
    task automatic run_stream(input int mode, input int max_cyc);
        int tx = 0;
        int c = 0;
        int n;
        logic hold = 1'b0;
        logic pend = 1'b0;
        logic [46:0] held = '0;
        n = src.size();
        rx.delete();
        while (rx.size() < n && c < max_cyc) begin
            @(negedge clk);
            if (mode == 0) bus.out_ready = (c >= 7);
            else           bus.out_ready = 1'($urandom_range(0, 1));
            if (!pend) begin
                bus.in_valid = (tx < n) && (mode == 0 || $urandom_range(0, 3) != 0);
                bus.in_data  = bus.in_valid ? src[tx] : $urandom;
            end
            #1;
            if (hold) begin
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                check("stall_hold", 64'(outs()), 64'(held));
            end
            if (mode == 0 && c == 4) begin
                check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                check("bp_hold_data", 64'(bus.out_data), 64'h80000000);
            end
            if (bus.out_valid && bus.out_ready) rx.push_back(outs());
            hold = bus.out_valid && !bus.out_ready;
            held = outs();
            pend = bus.in_valid && !bus.in_ready;
            if (bus.in_valid && bus.in_ready) tx++;
            c++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("stream_count", 64'(rx.size()), 64'(n));
    endtask

    logic [46:0] bp_exp[4];
    int stale;

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b1;
        bus24.in_valid  = 1'b0;
        bus24.in_data   = '0;
        bus24.out_ready = 1'b1;

        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_outs", 64'(outs()), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        single("one",    32'h00000001, {32'h80000000, 6'd31, 8'd127, 1'b0});
        single("msb",    32'h80000000, {32'h80000000, 6'd0,  8'd158, 1'b0});
        single("12345",  32'h00012345, {32'h91A28000, 6'd15, 8'd143, 1'b0});
        single("zero",   32'h00000000, {32'h00000000, 6'd32, 8'd0,   1'b1});
        single("ones",   32'hFFFFFFFF, {32'hFFFFFFFF, 6'd0,  8'd158, 1'b0});
        single("three",  32'h00000003, {32'hC0000000, 6'd30, 8'd128, 1'b0});
        single("f000",   32'h0000F000, {32'hF0000000, 6'd16, 8'd142, 1'b0});

        // 24-bit build
        @(negedge clk);
        bus24.in_valid = 1'b1;
        bus24.in_data  = 24'h000001;
        @(negedge clk);
        bus24.in_valid = 1'b0;
        @(negedge clk);
        check("w24_valid", 64'(bus24.out_valid), 64'd1);
        check("w24_data", 64'(bus24.out_data), 64'h800000);
        check("w24_shift", 64'(bus24.out_shift), 64'd23);
        check("w24_exp", 64'(bus24.out_exp), 64'd127);

        // Back-to-back under backpressure
        src.delete();
        src.push_back(32'd1);
        src.push_back(32'd2);
        src.push_back(32'd3);
        src.push_back(32'd4);
        bp_exp[0] = {32'h80000000, 6'd31, 8'd127, 1'b0};
        bp_exp[1] = {32'h80000000, 6'd30, 8'd128, 1'b0};
        bp_exp[2] = {32'hC0000000, 6'd30, 8'd128, 1'b0};
        bp_exp[3] = {32'h80000000, 6'd29, 8'd129, 1'b0};
        run_stream(0, 40);
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_item%0d", i), 64'(i < rx.size() ? rx[i] : 47'h0), 64'(bp_exp[i]));

        // Random data, random handshakes
        src.delete();
        for (int i = 0; i < 300; i++) begin
            if (i % 37 == 0) src.push_back(32'h0);
            else             src.push_back($urandom >> $urandom_range(0, 31));
        end
        run_stream(1, 4000);
        for (int i = 0; i < rx.size() && i < src.size(); i++)
            check($sformatf("rand_item%0d", i), 64'(rx[i]), 64'(model(src[i])));

        // Asynchronous reset with two items in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'd5;
        @(negedge clk);
        bus.in_data = 32'd6;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rst_pre_valid", 64'(bus.out_valid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(bus.out_valid), 64'd0);
        check("rst_async_data", 64'(bus.out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("no_stale", 64'(stale), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
